// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants for the timer subsystem: single-timer state
//               codes and the state codes of the timer arbiter FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Single hardware timer state codes
    localparam logic [1:0] TMR_STOP_S    = 2'd0;
    localparam logic [1:0] TMR_LOAD_S    = 2'd1;
    localparam logic [1:0] TMR_COUNT_S   = 2'd2;

    // Timer arbiter FSM state codes; any other code recovers to idle
    localparam logic [1:0] TARB_IDLE_S   = 2'd0;
    localparam logic [1:0] TARB_RUN_S    = 2'd1;
    localparam logic [1:0] TARB_EXPIRE_S = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit searching upward from ptr+1, wrapping at N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Doubling the request vector turns the wrapping search into a plain shift
    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_off;
    logic [IDX_W:0]     w_sum;

    assign w_req2 = {req, req};
    // Bit k of w_rot is req[(ptr+1+k) mod N_REQ]
    assign w_rot  = N_REQ'(w_req2 >> ({1'b0, ptr} + (IDX_W+1)'(1)));

    // Lowest set bit of the rotated vector is the next owner in RR order
    always_comb begin
        valid = 1'b0;
        w_off = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid && w_rot[k]) begin
                valid = 1'b1;
                w_off = (IDX_W+1)'(k + 1);
            end
        end
    end

    // Convert the offset back to an absolute index, wrapping once
    assign w_sum = {1'b0, ptr} + w_off;
    assign idx   = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                                 : IDX_W'(w_sum);

endmodule
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Shares one countdown timer among N_REQ requesters in
//               round-robin order, each for its own programmed duration.
//               Optional macro TMR_ARB_ABORT_EN adds an ABORT input that
//               ends the current run early.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 21
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
`ifdef TMR_ARB_ABORT_EN
    input  logic                       ABORT,
`endif
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ*CNT_W-1:0]     DUR,
    output logic [N_REQ-1:0]           GNT,
    output logic [$clog2(N_REQ)-1:0]   GNT_ID,
    output logic [N_REQ-1:0]           DONE,
    output logic                       BUSY
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [1:0]       r_state_q, w_state_d;
    logic [N_REQ-1:0] r_gnt_q,   w_gnt_d;
    logic [IDX_W-1:0] r_gnt_id_q, w_gnt_id_d;
    logic [N_REQ-1:0] r_done_q,  w_done_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [IDX_W-1:0] r_ptr_q,   w_ptr_d;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [CNT_W-1:0] w_dur_sel;
    logic             w_abort;

`ifdef TMR_ARB_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (r_ptr_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Duration slice belonging to the candidate winner
    always_comb begin
        w_dur_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_dur_sel = DUR[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state logic: grant in idle, count down in run, one-cycle expire
    always_comb begin
        w_state_d  = r_state_q;
        w_gnt_d    = r_gnt_q;
        w_gnt_id_d = r_gnt_id_q;
        w_done_d   = r_done_q;
        w_cnt_d    = r_cnt_q;
        w_ptr_d    = r_ptr_q;
        case (r_state_q)
            TARB_IDLE_S: begin
                w_done_d = '0;
                if (w_pick_valid) begin
                    w_gnt_d    = N_REQ'(1) << w_pick_idx;
                    w_gnt_id_d = w_pick_idx;
                    // A zero duration is clamped to one so the counter never wraps
                    w_cnt_d    = (w_dur_sel == '0) ? CNT_W'(1) : w_dur_sel;
                    w_state_d  = TARB_RUN_S;
                end
            end
            TARB_RUN_S: begin
                // Abort and natural expiry collapse into the same single DONE
                if (w_abort || (r_cnt_q == CNT_W'(1))) begin
                    w_gnt_d   = '0;
                    w_done_d  = N_REQ'(1) << r_gnt_id_q;
                    w_ptr_d   = r_gnt_id_q;
                    w_cnt_d   = '0;
                    w_state_d = TARB_EXPIRE_S;
                end else begin
                    w_cnt_d   = r_cnt_q - CNT_W'(1);
                end
            end
            TARB_EXPIRE_S: begin
                w_done_d  = '0;
                w_state_d = TARB_IDLE_S;
            end
            default: begin
                w_gnt_d   = '0;
                w_done_d  = '0;
                w_cnt_d   = '0;
                w_state_d = TARB_IDLE_S;
            end
        endcase
        // Soft clear aborts silently but keeps the fairness pointer
        if (CLR) begin
            w_state_d  = TARB_IDLE_S;
            w_gnt_d    = '0;
            w_gnt_id_d = '0;
            w_done_d   = '0;
            w_cnt_d    = '0;
        end
    end

    // State and output registers; pointer resets so requester 0 wins first
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q  <= TARB_IDLE_S;
            r_gnt_q    <= '0;
            r_gnt_id_q <= '0;
            r_done_q   <= '0;
            r_cnt_q    <= '0;
            r_ptr_q    <= IDX_W'(N_REQ - 1);
        end else begin
            r_state_q  <= w_state_d;
            r_gnt_q    <= w_gnt_d;
            r_gnt_id_q <= w_gnt_id_d;
            r_done_q   <= w_done_d;
            r_cnt_q    <= w_cnt_d;
            r_ptr_q    <= w_ptr_d;
        end
    end

    assign GNT    = r_gnt_q;
    assign GNT_ID = r_gnt_id_q;
    assign DONE   = r_done_q;
    assign BUSY   = (r_state_q != TARB_IDLE_S);

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Self-checking bench for timer_arbiter (N_REQ=4, CNT_W=4).
//               Optional macro TMR_ARB_ABORT_EN enables the abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           CLK   = 1'b0;
    logic           RST   = 1'b1;
    logic           CLR   = 1'b0;
    logic           ABORT = 1'b0;
    logic [N-1:0]   REQ   = '1;
    logic [N*W-1:0] DUR   = '0;
    logic [N-1:0]   GNT;
    logic [1:0]     GNT_ID;
    logic [N-1:0]   DONE;
    logic           BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CLR    (CLR),
`ifdef TMR_ARB_ABORT_EN
        .ABORT  (ABORT),
`endif
        .REQ    (REQ),
        .DUR    (DUR),
        .GNT    (GNT),
        .GNT_ID (GNT_ID),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: remaining grant cycles, pending done flag, owner, RR pointer
    int m_left  = 0;
    bit m_done  = 0;
    int m_owner = 0;
    int m_ptr   = N - 1;

    // Model advances on each rising edge from the inputs held across it
    always @(posedge CLK) begin
        int w, d;
        bit found;
        if (RST) begin
            m_left = 0; m_done = 0; m_owner = 0; m_ptr = N - 1;
        end else if (CLR) begin
            m_left = 0; m_done = 0; m_owner = 0;
        end else if (m_left > 0) begin
            if (m_left == 1 || ABORT) begin
                m_left = 0; m_done = 1; m_ptr = m_owner;
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                w = (m_ptr + k) % N;
                if (!found && REQ[w]) begin
                    found   = 1;
                    d       = int'(DUR[w*W +: W]);
                    m_owner = w;
                    m_left  = (d == 0) ? 1 : d;
                end
            end
        end
    end

    // Observed grant order, run lengths and DONE/GNT overlaps
    int grant_q[$];
    int len_q[$];
    int run_len   = 0;
    int n_overlap = 0;
    logic [N-1:0] prev_g = '0;

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge CLK) begin
        logic [N-1:0] eg, ed;
        logic         eb;
        eg = (m_left > 0) ? (N'(1) << m_owner) : '0;
        ed = m_done ? (N'(1) << m_owner) : '0;
        eb = (m_left > 0) || m_done;
        n_cmp++;
        if (GNT !== eg || DONE !== ed || BUSY !== eb || GNT_ID !== 2'(m_owner)) begin
            n_bad++;
            $display("FAIL model t=%0t GNT=%b want %b DONE=%b want %b BUSY=%b want %b ID=%0d want %0d",
                     $time, GNT, eg, DONE, ed, BUSY, eb, GNT_ID, m_owner);
        end
        if (GNT != '0 && DONE != '0) n_overlap++;
        if (GNT != '0) begin
            if (prev_g == '0) grant_q.push_back(int'(GNT_ID));
            run_len++;
        end else if (prev_g != '0) begin
            len_q.push_back(run_len);
            run_len = 0;
        end
        prev_g = GNT;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (BUSY !== 1'b0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk({nm, " idle"}, int'(BUSY === 1'b0), 1);
    endtask

    function automatic int last_len();
        return (len_q.size() > 0) ? len_q[$] : -1;
    endfunction

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset held two cycles with all requests asserted
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk("rst gnt",  int'(GNT),    0);
            chk("rst done", int'(DONE),   0);
            chk("rst busy", int'(BUSY),   0);
            chk("rst id",   int'(GNT_ID), 0);
        end
        RST = 1'b0;
        REQ = '0;
        @(negedge CLK);

        // Single request, duration 5
        REQ = 4'b0100;
        DUR[2*W +: W] = 4'd5;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = '0;
            if (c <= 5) begin
                chk("single gnt",  int'(GNT),  4);
                chk("single done", int'(DONE), 0);
            end else if (c == 6) begin
                chk("single gnt off", int'(GNT),  0);
                chk("single done",    int'(DONE), 4);
            end else begin
                chk("single busy", int'(BUSY), 0);
            end
        end

        // Round-robin with all requesters held, duration 2 each
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < N; i++) DUR[i*W +: W] = 4'd2;
        grant_q.delete();
        n_overlap = 0;
        REQ = '1;
        repeat (18) @(negedge CLK);
        REQ = '0;
        wait_idle("rr");
        chk("rr grants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_q.size()) chk("rr order", grant_q[i], exp_order[i]);
        end
        chk("rr overlap", n_overlap, 0);

        // All-ones duration on requester 3
        DUR[3*W +: W] = 4'hF;
        REQ = 4'b1000;
        @(negedge CLK);
        chk("max gnt latency", int'(GNT), 8);
        REQ = '0;
        wait_idle("max");
        chk("max len", last_len(), 15);

        // Zero duration on requester 1 behaves as one cycle
        DUR[1*W +: W] = 4'd0;
        REQ = 4'b0010;
        @(negedge CLK);
        REQ = '0;
        wait_idle("zero");
        chk("zero len", last_len(), 1);

        // Clear in the third cycle of a DUR=6 run; pointer is kept (last owner 1)
        DUR[2*W +: W] = 4'd6;
        DUR[0*W +: W] = 4'd3;
        REQ = 4'b0101;
        repeat (3) @(negedge CLK);
        chk("clr pre gnt", int'(GNT), 4);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr gnt",  int'(GNT),    0);
        chk("clr done", int'(DONE),   0);
        chk("clr busy", int'(BUSY),   0);
        chk("clr id",   int'(GNT_ID), 0);
        @(negedge CLK);
        chk("clr regrant", int'(GNT),    4);
        chk("clr reid",    int'(GNT_ID), 2);
        REQ = '0;
        wait_idle("clr");

`ifdef TMR_ARB_ABORT_EN
        // Abort in the second cycle of a DUR=10 run on requester 1
        DUR[1*W +: W] = 4'd10;
        REQ = 4'b0110;
        repeat (2) @(negedge CLK);
        chk("abort pre gnt", int'(GNT), 2);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        REQ = 4'b0100;
        chk("abort gnt",  int'(GNT),  0);
        chk("abort done", int'(DONE), 2);
        @(negedge CLK);
        chk("abort done off", int'(DONE), 0);
        @(negedge CLK);
        chk("abort next", int'(GNT), 4);
        REQ = '0;
        wait_idle("abort");
        chk("abort len", (len_q.size() > 1) ? len_q[len_q.size()-2] : -1, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
